// File: rtl/spg_pkg.sv
// ---------------------------------------------------------------------------
// spg_pkg -- shared types and constants for serial_pattern_gen.
//   state_t   : transmitter FSM states (2-bit encoding)
//   RST_STATE : state entered on reset
//   RST_OUT   : value of every registered output while in reset
// ---------------------------------------------------------------------------
package spg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_OUT   = 1'b0;

endpackage

// File: rtl/spg_shift_reg.sv
// ---------------------------------------------------------------------------
// spg_shift_reg -- left-shifting register with parallel load.
//   clk      in  : clock, state on posedge
//   clr      in  : asynchronous active-high clear
//   load_en  in  : load load_val (has priority over shift_en)
//   shift_en in  : shift left by one, zero fill
//   load_val in  : WIDTH-bit parallel load value
//   msb      out : current MSB of the register
// ---------------------------------------------------------------------------
module spg_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next-state selection: load wins over shift, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// serial_pattern_gen -- shifts a WIDTH-bit pattern out MSB-first, repeat_n
// times, with GAP idle cycles between repetitions, then pulses done.
//   clk      in  : clock, all state on posedge
//   rst      in  : asynchronous active-high reset
//   start    in  : request, sampled only while busy=0
//   pattern  in  : WIDTH bits to send, MSB first
//   repeat_n in  : number of pattern transmissions (0 = none)
//   abort    in  : (only with SPG_ABORT_EN) cancel a running frame
//   w        out : serial data, 0 whenever w_valid=0
//   w_valid  out : w carries a pattern bit this cycle
//   busy     out : transmission in progress
//   done     out : one-cycle completion pulse
// Build option: define SPG_ABORT_EN to add the abort input.
// All outputs are registered; they are computed from the next state.
// ---------------------------------------------------------------------------
module serial_pattern_gen
  import spg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
`ifdef SPG_ABORT_EN
  input  logic             abort,
`endif
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W    = $clog2(WIDTH);
  localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST_C = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_LAST);

  state_t             state_q,   state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   rep_q,     rep_d;
  logic [WIDTH-1:0]   pat_q,     pat_d;
  logic               w_q,       w_d;
  logic               w_valid_q, w_valid_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic               sr_load;
  logic               sr_shift;
  logic [WIDTH-1:0]   sr_val;
  logic               sr_msb;
  logic               abort_s;

`ifdef SPG_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // The shift register holds only the bits still to be sent after the one
  // currently on w, so its MSB is always the next bit of the repetition.
  spg_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .clr      (rst),
    .load_en  (sr_load),
    .shift_en (sr_shift),
    .load_val (sr_val),
    .msb      (sr_msb)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rep_d     = rep_q;
    pat_d     = pat_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_val    = {pat_q[WIDTH-2:0], 1'b0};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d     = pattern;
          rep_d     = repeat_n;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          if (repeat_n == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_SHIFT;
            sr_load   = 1'b1;
            sr_val    = {pattern[WIDTH-2:0], 1'b0};
            w_d       = pattern[WIDTH-1];
            w_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q != BIT_LAST_C) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          w_d       = sr_msb;
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (rep_q != CNT_W'(1)) begin
          // More repetitions: rearm the shifter from the latched pattern.
          rep_d     = rep_q - CNT_W'(1);
          bit_cnt_d = '0;
          sr_load   = 1'b1;
          busy_d    = 1'b1;
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            w_d       = pat_q[WIDTH-1];
            w_valid_d = 1'b1;
          end
        end else begin
          rep_d   = rep_q - CNT_W'(1);
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_LAST_C) begin
          // Shifter was already reloaded on entry to the gap.
          state_d   = S_SHIFT;
          gap_cnt_d = '0;
          w_d       = pat_q[WIDTH-1];
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_q     <= '0;
      pat_q     <= '0;
      w_q       <= RST_OUT;
      w_valid_q <= RST_OUT;
      busy_q    <= RST_OUT;
      done_q    <= RST_OUT;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rep_q     <= rep_d;
      pat_q     <= pat_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_gen -- two generators (GAP=0 and GAP=2) share one set of
// inputs. A frame-level model expands each accepted start into the expected
// per-cycle output stream; one process compares every cycle, and directed
// frames are additionally checked against hand-written literal values.
// ---------------------------------------------------------------------------
module tb_serial_pattern_gen;

  localparam int W  = 4;
  localparam int CW = 8;

  typedef logic [3:0] out_t;  // {w, w_valid, busy, done}
  localparam out_t O_IDLE = 4'b0000;
  localparam out_t O_DONE = 4'b0001;
  localparam out_t O_GAP  = 4'b0010;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  pattern;
  logic [CW-1:0] repeat_n;
`ifdef SPG_ABORT_EN
  logic          abort;
`endif
  logic w0, v0, b0, d0;
  logic w1, v1, b1, d1;

  int total = 0;
  int bad   = 0;

  out_t q0[$];
  out_t q1[$];
  out_t cur0 = O_IDLE;
  out_t cur1 = O_IDLE;

  serial_pattern_gen #(.WIDTH(W), .CNT_W(CW), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
`ifdef SPG_ABORT_EN
    .abort(abort),
`endif
    .w(w0), .w_valid(v0), .busy(b0), .done(d0)
  );

  serial_pattern_gen #(.WIDTH(W), .CNT_W(CW), .GAP(2)) u_gap2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
`ifdef SPG_ABORT_EN
    .abort(abort),
`endif
    .w(w1), .w_valid(v1), .busy(b1), .done(d1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- frame-level reference model ----------------
  function automatic void push(input int idx, input out_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endfunction

  function automatic void flush(input int idx);
    if (idx == 0) q0.delete();
    else          q1.delete();
  endfunction

  // Whole frame: r repetitions of the bits, gaps between them, then done.
  function automatic void build(input int idx, input int gap, input logic [W-1:0] p, input int r);
    if (r == 0) begin
      push(idx, O_DONE);
    end else begin
      for (int k = 0; k < r; k++) begin
        for (int i = W - 1; i >= 0; i--) push(idx, {p[i], 3'b110});
        if (k < r - 1) for (int g = 0; g < gap; g++) push(idx, O_GAP);
      end
      push(idx, O_DONE);
    end
  endfunction

  function automatic out_t advance(input int idx, input int gap, input out_t cur);
    logic ab;
    ab = 1'b0;
`ifdef SPG_ABORT_EN
    ab = abort;
`endif
    if (ab && cur[1]) begin
      flush(idx);
      return O_IDLE;
    end
    if (!cur[1] && start) begin
      flush(idx);
      build(idx, gap, pattern, int'(repeat_n));
    end
    if (idx == 0) begin
      if (q0.size() > 0) return q0.pop_front();
    end else begin
      if (q1.size() > 0) return q1.pop_front();
    end
    return O_IDLE;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      flush(0);
      flush(1);
      cur0 = O_IDLE;
      cur1 = O_IDLE;
    end else begin
      cur0 = advance(0, 0, cur0);
      cur1 = advance(1, 2, cur1);
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic out_t get(input int inst);
    return (inst == 0) ? {w0, v0, b0, d0} : {w1, v1, b1, d1};
  endfunction

  task automatic chk(input string nm, input int inst, input out_t exp);
    cmp(nm, 32'(get(inst)), 32'(exp));
  endtask

  // Per-cycle compare of both generators against the model.
  initial forever begin
    @(negedge clk);
    cmp("cycle_gap0", 32'(get(0)), 32'(cur0));
    cmp("cycle_gap2", 32'(get(1)), 32'(cur1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of cycle t+1.
  task automatic drive_start(input logic [W-1:0] p, input logic [CW-1:0] r);
    start    = 1'b1;
    pattern  = p;
    repeat_n = r;
    @(negedge clk);
    start    = 1'b0;
    pattern  = W'($urandom);
    repeat_n = CW'($urandom);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e4;
    int d0c;
    int d1c;
    rst      = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
`ifdef SPG_ABORT_EN
    abort    = 1'b0;
`endif
    #1 rst = 1'b1;
    step();
    chk("reset_gap0", 0, O_IDLE);
    chk("reset_gap2", 1, O_IDLE);
    step();
    rst = 1'b0;
    idle(2);

    // 1001 once: bits at t+1..t+4, done at t+5
    e4 = 4'b1001;
    drive_start(e4, 8'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_bit", 0, {e4[3-k], 3'b110});
      step();
    end
    chk("t1_done", 0, O_DONE);
    idle(8);

    // 1111 x3 back-to-back: 12 ones, done at t+13
    drive_start(4'b1111, 8'd3);
    for (int k = 0; k < 12; k++) begin
      chk("t2_bit", 0, 4'b1110);
      step();
    end
    chk("t2_done", 0, O_DONE);
    idle(8);

    // repeat=0: done at t+1, never busy or valid
    drive_start(4'b1011, 8'd0);
    chk("t3_done_gap0", 0, O_DONE);
    chk("t3_done_gap2", 1, O_DONE);
    step();
    chk("t3_after", 0, O_IDLE);
    idle(4);

    // GAP=2, 1010 x2: bits, two idle-busy cycles, bits, done at t+11
    e4 = 4'b1010;
    drive_start(e4, 8'd2);
    for (int k = 0; k < 4; k++) begin
      chk("t4_bit_a", 1, {e4[3-k], 3'b110});
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk("t4_gap", 1, O_GAP);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("t4_bit_b", 1, {e4[3-k], 3'b110});
      step();
    end
    chk("t4_done", 1, O_DONE);
    idle(8);

    // reset during the second bit, then a clean frame
    e4 = 4'b1001;
    drive_start(e4, 8'd1);
    step();
    chk("t5_bit2", 0, 4'b0110);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_gap0", 0, O_IDLE);
    chk("t5_rst_gap2", 1, O_IDLE);
    step();
    rst = 1'b0;
    idle(6);
    drive_start(e4, 8'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t5_bit", 0, {e4[3-k], 3'b110});
      step();
    end
    chk("t5_done", 0, O_DONE);
    idle(8);

    // start while busy is ignored
    drive_start(e4, 8'd1);
    step();
    start    = 1'b1;
    pattern  = 4'b0110;
    repeat_n = 8'd5;
    chk("t6_bit2", 0, 4'b0110);
    step();
    start = 1'b0;
    chk("t6_bit3", 0, 4'b0110);
    step();
    chk("t6_bit4", 0, 4'b1110);
    step();
    chk("t6_done", 0, O_DONE);
    step();
    chk("t6_idle", 0, O_IDLE);
    idle(8);

`ifdef SPG_ABORT_EN
    // abort during bit 3: idle next cycle, no done
    drive_start(e4, 8'd1);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_next", 0, O_IDLE);
    step();
    chk("abort_nodone", 0, O_IDLE);
    idle(8);
`endif

    // maximum repeat count: done at t+1+255*4 and t+1+255*4+254*2
    drive_start(4'b1100, 8'd255);
    d0c = 0;
    d1c = 0;
    for (int n = 1; n <= 1700 && (d0c == 0 || d1c == 0); n++) begin
      if (d0 && d0c == 0) d0c = n;
      if (d1 && d1c == 0) d1c = n;
      step();
    end
    cmp("rep255_gap0_latency", 32'(d0c), 32'd1021);
    cmp("rep255_gap2_latency", 32'(d1c), 32'd1529);
    idle(4);

    // randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      pattern  = W'($urandom);
      repeat_n = ($urandom_range(0, 15) == 0) ? 8'd0 : CW'($urandom_range(1, 4));
`ifdef SPG_ABORT_EN
      abort    = ($urandom_range(0, 40) == 0);
`endif
      if ($urandom_range(0, 400) == 0) pulse_reset();
    end
    start = 1'b0;
`ifdef SPG_ABORT_EN
    abort = 1'b0;
`endif
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
